// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Register scoreboard for the in-order pipeline. It keeps one saturating
//   in-flight counter per architectural register. From these counters it
//   derives the decode dependency stall, which covers RAW hazards and counter
//   saturation. Writers that are squashed on a branch redirect release their
//   reservation through the kill port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears all reservations and err)
//   issue_v    decode presents a valid instruction
//   issue_wen  instruction writes a destination register
//   issue_dr   destination register index
//   rs         NRD source indices, port k at [k*RW +: RW]
//   rs_use     per-port "source is actually read"
//   ret_v      writeback retires a register write this cycle
//   ret_dr     retiring destination index
//   kill_v     squashed in-flight writer releases its reservation
//   kill_dr    squashed writer's destination index
//   stall      hold decode, issue not accepted (combinational)
//   busy       bit r set while register r has writers in flight
//   err        sticky: some counter was decremented below zero
// ---------------------------------------------------------------------------
module reg_scoreboard #(
   parameter int NREG      = 32,
   parameter int NRD       = 2,
   parameter int CNTW      = 2,
   parameter int WB_BYPASS = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          issue_v,
   input  logic                          issue_wen,
   input  logic [$clog2(NREG)-1:0]       issue_dr,
   input  logic [NRD*$clog2(NREG)-1:0]   rs,
   input  logic [NRD-1:0]                rs_use,
   input  logic                          ret_v,
   input  logic [$clog2(NREG)-1:0]       ret_dr,
   input  logic                          kill_v,
   input  logic [$clog2(NREG)-1:0]       kill_dr,
   output logic                          stall,
   output logic [NREG-1:0]               busy,
   output logic                          err
);

   localparam int RW = $clog2(NREG);
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
   localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [RW-1:0]   IDX_ZERO = {RW{1'b0}};

   logic [CNTW-1:0] cnt_r      [NREG];
   logic [CNTW-1:0] cnt_next_s [NREG];
   logic            err_r;
   logic            under_s;
   logic [RW-1:0]   rs_idx_s   [NRD];
   logic            raw_s;
   logic            sat_s;
   logic            acc_s;

   // Next counter value: {underflow, clamped count}. At most one increment and
   // two decrements. A result below zero clamps to zero and flags underflow.
   function automatic logic [CNTW:0] cnt_update(input logic [CNTW-1:0] cur,
                                                input logic            inc,
                                                input logic            dec_a,
                                                input logic            dec_b);
      logic [CNTW+1:0] up;
      logic [CNTW+1:0] dn;
      up = {2'b00, cur} + {{(CNTW+1){1'b0}}, inc};
      dn = {{(CNTW+1){1'b0}}, dec_a} + {{(CNTW+1){1'b0}}, dec_b};
      if (up < dn) begin
         cnt_update = {1'b1, CNT_ZERO};
      end else begin
         cnt_update = {1'b0, CNT_ZERO} + {1'b0, up[CNTW-1:0] - dn[CNTW-1:0]};
      end
   endfunction

   // Split the packed source bus into per-port indices.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rs_idx_s[k] = rs[k*RW +: RW];
      end
   end

   // RAW detection. A retiring last writer is bypassed when WB_BYPASS is set.
   always_comb begin
      raw_s = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         if (rs_use[k] && (rs_idx_s[k] != IDX_ZERO) && (cnt_r[rs_idx_s[k]] != CNT_ZERO)) begin
            if ((WB_BYPASS != 0) && ret_v && (ret_dr == rs_idx_s[k]) &&
                (cnt_r[rs_idx_s[k]] == CNT_ONE)) begin
               raw_s = raw_s;
            end else begin
               raw_s = 1'b1;
            end
         end else begin
            raw_s = raw_s;
         end
      end
   end

   // Saturation stall (not relieved by a same-cycle retire), overall stall and acceptance.
   always_comb begin
      sat_s = issue_wen && (issue_dr != IDX_ZERO) && (cnt_r[issue_dr] == CNT_MAX);
      stall = issue_v && (raw_s || sat_s);
      acc_s = issue_v && !stall && issue_wen && (issue_dr != IDX_ZERO);
   end

   // Per-register next counts. Register 0 is hardwired and never changes.
   always_comb begin
      under_s = 1'b0;
      cnt_next_s[0] = CNT_ZERO;
      for (int r = 1; r < NREG; r++) begin
         logic [CNTW:0] upd;
         upd = cnt_update(cnt_r[r],
                          acc_s  && (issue_dr == RW'(r)),
                          ret_v  && (ret_dr   == RW'(r)),
                          kill_v && (kill_dr  == RW'(r)));
         cnt_next_s[r] = upd[CNTW-1:0];
         under_s       = under_s | upd[CNTW];
      end
   end

   // Counter and sticky error state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_r[r] <= CNT_ZERO;
         end
         err_r <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_r[r] <= cnt_next_s[r];
         end
         if (under_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   // Busy vector decoded directly from the counter flops.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         busy[r] = (cnt_r[r] != CNT_ZERO);
      end
      err = err_r;
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        issue_v, issue_wen;
   logic [4:0]  issue_dr;
   logic [9:0]  rs;
   logic [1:0]  rs_use;
   logic        ret_v, kill_v;
   logic [4:0]  ret_dr, kill_dr;
   logic        stall_a, stall_b, err_a, err_b;
   logic [31:0] busy_a, busy_b;
   int          nvec;
   int          nbad;

   reg_scoreboard #(.NREG(32), .NRD(2), .CNTW(2), .WB_BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .issue_v(issue_v), .issue_wen(issue_wen),
      .issue_dr(issue_dr), .rs(rs), .rs_use(rs_use), .ret_v(ret_v),
      .ret_dr(ret_dr), .kill_v(kill_v), .kill_dr(kill_dr),
      .stall(stall_a), .busy(busy_a), .err(err_a));

   reg_scoreboard #(.NREG(32), .NRD(2), .CNTW(2), .WB_BYPASS(0)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .issue_v(issue_v), .issue_wen(issue_wen),
      .issue_dr(issue_dr), .rs(rs), .rs_use(rs_use), .ret_v(ret_v),
      .ret_dr(ret_dr), .kill_v(kill_v), .kill_dr(kill_dr),
      .stall(stall_b), .busy(busy_b), .err(err_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      issue_v = 1'b0; issue_wen = 1'b0; issue_dr = 5'd0;
      rs = 10'd0; rs_use = 2'b00;
      ret_v = 1'b0; ret_dr = 5'd0; kill_v = 1'b0; kill_dr = 5'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] dr);
      idle();
      issue_v = 1'b1; issue_wen = 1'b1; issue_dr = dr;
      step();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #2;
      nvec++; if (busy_a !== 32'h0) begin $display("FAIL reset_busy_a got=%h exp=%h", busy_a, 32'h0); nbad++; end
      nvec++; if (busy_b !== 32'h0) begin $display("FAIL reset_busy_b got=%h exp=%h", busy_b, 32'h0); nbad++; end
      nvec++; if (err_a !== 1'b0 || err_b !== 1'b0) begin $display("FAIL reset_err got=%b%b exp=00", err_a, err_b); nbad++; end
      nvec++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin $display("FAIL reset_stall got=%b%b exp=00", stall_a, stall_b); nbad++; end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_raw();
      issue(5'd5);
      idle();
      issue_v = 1'b1; rs = {5'd0, 5'd5}; rs_use = 2'b01;
      #1;
      nvec++; if (stall_a !== 1'b1 || stall_b !== 1'b1) begin $display("FAIL raw_port0_stall got=%b%b exp=11", stall_a, stall_b); nbad++; end
      nvec++; if (busy_a[5] !== 1'b1 || busy_b[5] !== 1'b1) begin $display("FAIL raw_busy5 got=%b%b exp=11", busy_a[5], busy_b[5]); nbad++; end
      rs = {5'd5, 5'd0}; rs_use = 2'b10;
      #1;
      nvec++; if (stall_a !== 1'b1) begin $display("FAIL raw_port1_stall got=%b exp=1", stall_a); nbad++; end
      rs = {5'd5, 5'd5}; rs_use = 2'b00;
      #1;
      nvec++; if (stall_a !== 1'b0) begin $display("FAIL raw_unused_stall got=%b exp=0", stall_a); nbad++; end
      rs = {5'd0, 5'd6}; rs_use = 2'b11;
      #1;
      nvec++; if (stall_a !== 1'b0) begin $display("FAIL raw_other_reg_stall got=%b exp=0", stall_a); nbad++; end
   endtask

   task automatic test_bypass();
      idle();
      issue_v = 1'b1; rs = {5'd0, 5'd5}; rs_use = 2'b01;
      ret_v = 1'b1; ret_dr = 5'd5;
      #1;
      nvec++; if (stall_a !== 1'b0) begin $display("FAIL bypass_on_stall got=%b exp=0", stall_a); nbad++; end
      nvec++; if (stall_b !== 1'b1) begin $display("FAIL bypass_off_stall got=%b exp=1", stall_b); nbad++; end
      step();
      idle();
      nvec++; if (busy_a[5] !== 1'b0 || busy_b[5] !== 1'b0) begin $display("FAIL bypass_busy5_after got=%b%b exp=00", busy_a[5], busy_b[5]); nbad++; end
   endtask

   task automatic test_reg0();
      idle();
      issue_v = 1'b1; issue_wen = 1'b1; issue_dr = 5'd0; rs = 10'd0; rs_use = 2'b01;
      #1;
      nvec++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin $display("FAIL reg0_stall got=%b%b exp=00", stall_a, stall_b); nbad++; end
      step();
      idle();
      ret_v = 1'b1; ret_dr = 5'd0; kill_v = 1'b1; kill_dr = 5'd0;
      step();
      idle();
      nvec++; if (busy_a !== 32'h0) begin $display("FAIL reg0_busy got=%h exp=%h", busy_a, 32'h0); nbad++; end
      nvec++; if (err_a !== 1'b0) begin $display("FAIL reg0_err got=%b exp=0", err_a); nbad++; end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) begin
         idle();
         issue_v = 1'b1; issue_wen = 1'b1; issue_dr = 5'd7;
         #1;
         nvec++; if (stall_a !== 1'b0) begin $display("FAIL sat_fill%0d_stall got=%b exp=0", i, stall_a); nbad++; end
         step();
      end
      idle();
      issue_v = 1'b1; issue_wen = 1'b1; issue_dr = 5'd7;
      #1;
      nvec++; if (stall_a !== 1'b1) begin $display("FAIL sat_full_stall got=%b exp=1", stall_a); nbad++; end
      step();
      ret_v = 1'b1; ret_dr = 5'd7;
      #1;
      nvec++; if (stall_a !== 1'b1) begin $display("FAIL sat_retire_same_cycle_stall got=%b exp=1", stall_a); nbad++; end
      step();
      ret_v = 1'b0;
      #1;
      nvec++; if (stall_a !== 1'b0) begin $display("FAIL sat_after_retire_stall got=%b exp=0", stall_a); nbad++; end
      step();
      #1;
      nvec++; if (stall_a !== 1'b1) begin $display("FAIL sat_refull_stall got=%b exp=1", stall_a); nbad++; end
      for (int i = 0; i < 3; i++) begin
         idle();
         ret_v = 1'b1; ret_dr = 5'd7;
         step();
      end
      idle();
      nvec++; if (busy_a[7] !== 1'b0 || err_a !== 1'b0) begin $display("FAIL sat_drain got=busy%b err%b exp=busy0 err0", busy_a[7], err_a); nbad++; end
   endtask

   task automatic test_retire_kill();
      issue(5'd9);
      issue(5'd9);
      idle();
      issue_v = 1'b1; issue_wen = 1'b1; issue_dr = 5'd9; ret_v = 1'b1; ret_dr = 5'd9;
      #1;
      nvec++; if (stall_a !== 1'b0) begin $display("FAIL rk_issue_ret_stall got=%b exp=0", stall_a); nbad++; end
      step();
      idle();
      ret_v = 1'b1; ret_dr = 5'd9; kill_v = 1'b1; kill_dr = 5'd9;
      step();
      idle();
      nvec++; if (busy_a[9] !== 1'b0) begin $display("FAIL rk_first_busy9 got=%b exp=0", busy_a[9]); nbad++; end
      nvec++; if (err_a !== 1'b0) begin $display("FAIL rk_first_err got=%b exp=0", err_a); nbad++; end
      ret_v = 1'b1; ret_dr = 5'd9; kill_v = 1'b1; kill_dr = 5'd9;
      step();
      idle();
      nvec++; if (err_a !== 1'b1 || err_b !== 1'b1) begin $display("FAIL rk_under_err got=%b%b exp=11", err_a, err_b); nbad++; end
      nvec++; if (busy_a[9] !== 1'b0) begin $display("FAIL rk_under_busy9 got=%b exp=0", busy_a[9]); nbad++; end
      step();
      nvec++; if (err_a !== 1'b1) begin $display("FAIL rk_err_sticky got=%b exp=1", err_a); nbad++; end
   endtask

   task automatic test_reset_mid();
      issue(5'd3);
      issue(5'd3);
      idle();
      nvec++; if (busy_a[3] !== 1'b1) begin $display("FAIL mid_busy3_before got=%b exp=1", busy_a[3]); nbad++; end
      issue_v = 1'b1; issue_wen = 1'b1; issue_dr = 5'd3;
      #1;
      rst_n = 1'b0;
      #1;
      nvec++; if (busy_a !== 32'h0 || busy_b !== 32'h0) begin $display("FAIL mid_busy got=%h/%h exp=%h", busy_a, busy_b, 32'h0); nbad++; end
      nvec++; if (err_a !== 1'b0 || err_b !== 1'b0) begin $display("FAIL mid_err got=%b%b exp=00", err_a, err_b); nbad++; end
      idle();
      #1;
      rst_n = 1'b1;
      step();
      nvec++; if (busy_a !== 32'h0) begin $display("FAIL mid_busy_after_release got=%h exp=%h", busy_a, 32'h0); nbad++; end
   endtask

   initial begin
      nvec = 0;
      nbad = 0;
      test_reset();
      test_raw();
      test_bypass();
      test_reg0();
      test_saturate();
      test_retire_kill();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
